// File: rtl/obj_scanner.sv
// ============================================================================
// Module   : obj_scanner
// Purpose  : Per-frame walk of the obstacle FIFO. Streams visible objects,
//            detects player collisions and pops objects left behind.
//            Optional macro OBJ_SCANNER_COIN_EN turns type 3 into a coin.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module obj_scanner #(
    parameter int          ADDR_WIDTH = 4,
    parameter logic [11:0] VIEW_DIST  = 12'd400,
    parameter logic [11:0] HIT_WIN    = 12'd8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [11:0]           scroll_pos,
    input  logic [1:0]            player_lane,
    input  logic                  player_jump,
    input  logic                  player_slide,
    input  logic [ADDR_WIDTH:0]   num,
    input  logic [15:0]           rd_obj,
    output logic [ADDR_WIDTH-1:0] rd_index,
    output logic                  pop,
    output logic                  obj_valid,
    output logic [11:0]           obj_rel,
    output logic [1:0]            obj_lane,
    output logic [1:0]            obj_type,
    output logic                  busy,
    output logic                  done,
    output logic                  hit,
    output logic [1:0]            hit_type,
    output logic                  coin
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_POP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    logic [11:0]           r_scroll;
    logic [1:0]            r_lane;
    logic                  r_jump;
    logic                  r_slide;
    logic [ADDR_WIDTH:0]   r_n;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH:0]   r_pass_cnt;
    logic [ADDR_WIDTH:0]   r_pop_cnt;
    logic                  r_front_run;
    logic                  r_hit_flag;
    logic [1:0]            r_hit_type_cap;
    logic                  r_pop;
    logic                  r_obj_valid;
    logic [11:0]           r_obj_rel;
    logic [1:0]            r_obj_lane;
    logic [1:0]            r_obj_type;
    logic                  r_done;
    logic                  r_hit;
    logic [1:0]            r_hit_type;

    logic [11:0] w_pos;
    logic [1:0]  w_lane;
    logic [1:0]  w_type;
    logic [11:0] w_rel;
    logic        w_behind;
    logic        w_active;
    logic        w_overlap;
    logic        w_visible;
    logic        w_type_hits;
    logic        w_collide;
    logic        w_last;

    assign w_pos     = rd_obj[11:0];
    assign w_lane    = rd_obj[13:12];
    assign w_type    = rd_obj[15:14];
    assign w_rel     = w_pos - r_scroll;
    assign w_behind  = w_rel[11];
    // Lane 3 marks empty slots and is excluded from every decision
    assign w_active  = (w_lane != 2'd3);
    assign w_overlap = w_active && (w_rel < HIT_WIN) && (w_lane == r_lane);
    assign w_visible = w_active && !w_behind && (w_rel < VIEW_DIST);
    assign w_last    = ({1'b0, r_idx} == (r_n - 1'b1));

    always_comb begin
        w_type_hits = 1'b0;
        case (w_type)
            2'd0:    w_type_hits = 1'b1;
            2'd1:    w_type_hits = !r_jump;
            2'd2:    w_type_hits = !r_slide;
`ifdef OBJ_SCANNER_COIN_EN
            default: w_type_hits = 1'b0;
`else
            default: w_type_hits = 1'b1;
`endif
        endcase
    end

    assign w_collide = w_overlap && w_type_hits;

`ifdef OBJ_SCANNER_COIN_EN
    logic r_coin_flag;
    logic r_coin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_coin_flag <= 1'b0;
            r_coin      <= 1'b0;
        end else begin
            r_coin <= 1'b0;
            if (r_state == S_IDLE && frame_start) begin
                r_coin_flag <= 1'b0;
            end else if (r_state == S_SCAN && w_overlap && w_type == 2'd3) begin
                r_coin_flag <= 1'b1;
            end else if (r_state == S_POP && r_pop_cnt == r_pass_cnt) begin
                r_coin <= r_coin_flag;
            end
        end
    end

    assign coin = r_coin;
`else
    assign coin = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_scroll       <= '0;
            r_lane         <= '0;
            r_jump         <= 1'b0;
            r_slide        <= 1'b0;
            r_n            <= '0;
            r_idx          <= '0;
            r_pass_cnt     <= '0;
            r_pop_cnt      <= '0;
            r_front_run    <= 1'b0;
            r_hit_flag     <= 1'b0;
            r_hit_type_cap <= '0;
            r_pop          <= 1'b0;
            r_obj_valid    <= 1'b0;
            r_obj_rel      <= '0;
            r_obj_lane     <= '0;
            r_obj_type     <= '0;
            r_done         <= 1'b0;
            r_hit          <= 1'b0;
            r_hit_type     <= '0;
        end else begin
            r_pop       <= 1'b0;
            r_obj_valid <= 1'b0;
            r_done      <= 1'b0;
            r_hit       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_scroll       <= scroll_pos;
                        r_lane         <= player_lane;
                        r_jump         <= player_jump;
                        r_slide        <= player_slide;
                        r_n            <= num;
                        r_idx          <= '0;
                        r_pass_cnt     <= '0;
                        r_pop_cnt      <= '0;
                        r_front_run    <= 1'b1;
                        r_hit_flag     <= 1'b0;
                        r_hit_type_cap <= '0;
                        r_state        <= (num == '0) ? S_POP : S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_visible) begin
                        r_obj_valid <= 1'b1;
                        r_obj_rel   <= w_rel;
                        r_obj_lane  <= w_lane;
                        r_obj_type  <= w_type;
                    end
                    // Only the unbroken run of passed objects at the front may be popped
                    if (w_active) begin
                        if (w_behind && r_front_run) begin
                            r_pass_cnt <= r_pass_cnt + 1'b1;
                        end else begin
                            r_front_run <= 1'b0;
                        end
                    end
                    if (w_collide && !r_hit_flag) begin
                        r_hit_flag     <= 1'b1;
                        r_hit_type_cap <= w_type;
                    end
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        r_state <= S_POP;
                    end
                end
                S_POP: begin
                    if (r_pop_cnt == r_pass_cnt) begin
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_hit      <= r_hit_flag;
                        r_hit_type <= r_hit_type_cap;
                    end else begin
                        r_pop     <= 1'b1;
                        r_pop_cnt <= r_pop_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_index  = r_idx;
    assign pop       = r_pop;
    assign obj_valid = r_obj_valid;
    assign obj_rel   = r_obj_rel;
    assign obj_lane  = r_obj_lane;
    assign obj_type  = r_obj_type;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign hit       = r_hit;
    assign hit_type  = r_hit_type;

endmodule

`default_nettype wire

// File: tb/tb_obj_scanner.sv
// ============================================================================
// Module   : tb_obj_scanner
// Purpose  : Table-driven frame vectors plus reset, empty and full-queue runs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_obj_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [11:0] scroll_pos;
    logic [1:0]  player_lane;
    logic        player_jump;
    logic        player_slide;
    logic [4:0]  num;
    logic [15:0] rd_obj;
    logic [3:0]  rd_index;
    logic        pop;
    logic        obj_valid;
    logic [11:0] obj_rel;
    logic [1:0]  obj_lane;
    logic [1:0]  obj_type;
    logic        busy;
    logic        done;
    logic        hit;
    logic [1:0]  hit_type;
    logic        coin;

    obj_scanner dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .scroll_pos(scroll_pos), .player_lane(player_lane),
        .player_jump(player_jump), .player_slide(player_slide),
        .num(num), .rd_obj(rd_obj), .rd_index(rd_index), .pop(pop),
        .obj_valid(obj_valid), .obj_rel(obj_rel), .obj_lane(obj_lane),
        .obj_type(obj_type), .busy(busy), .done(done), .hit(hit),
        .hit_type(hit_type), .coin(coin)
    );

    always #5 clk = ~clk;

    // FIFO model: front at mem[0], pop shifts everything down
    logic [15:0] mem [16];
    int          cnt = 0;
    int          pop_total = 0;

    always @(posedge clk) begin
        if (pop) begin
            pop_total <= pop_total + 1;
            if (cnt > 0) begin
                for (int k = 0; k < 15; k++) mem[k] <= mem[k+1];
                mem[15] <= 16'hF7FF;
                cnt     <= cnt - 1;
            end
        end
    end

    assign num    = cnt[4:0];
    assign rd_obj = (int'({1'b0, rd_index}) < cnt) ? mem[rd_index] : 16'hF7FF;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic logic [15:0] mk(input int pos, input int lane, input int typ);
        mk = {typ[1:0], lane[1:0], pos[11:0]};
    endfunction

    typedef struct {
        logic [2:0][15:0] obj;
        int          n;
        logic [11:0] scroll;
        logic [1:0]  lane;
        logic        jump;
        logic        slide;
        int          beats;
        logic [11:0] rel0;
        logic [11:0] rel1;
        int          pops;
        logic        hit;
        logic [1:0]  htype;
        logic        coin;
        int          cnt_after;
    } vec_t;

    function automatic vec_t V(input logic [15:0] o0, o1, o2, input int n,
                               input int scroll, lane, jump, slide, beats,
                               input int rel0, rel1, pops, h, ht, c, ca);
        vec_t v;
        v.obj = {o2, o1, o0};
        v.n = n; v.scroll = scroll[11:0]; v.lane = lane[1:0];
        v.jump = jump[0]; v.slide = slide[0]; v.beats = beats;
        v.rel0 = rel0[11:0]; v.rel1 = rel1[11:0]; v.pops = pops;
        v.hit = h[0]; v.htype = ht[1:0]; v.coin = c[0]; v.cnt_after = ca;
        return v;
    endfunction

    logic [11:0] got_rel [2];

    task automatic load(input logic [2:0][15:0] o, input int n);
        for (int k = 0; k < 16; k++) mem[k] = 16'hF7FF;
        for (int k = 0; k < n && k < 3; k++) mem[k] = o[k];
        cnt = n;
    endtask

    task automatic run_frame(output int beats, output int pops, output int lat,
                             output int busy_cyc, output logic h,
                             output logic [1:0] ht, output logic c);
        beats = 0; pops = 0; busy_cyc = 0;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            if (obj_valid) begin
                if (beats < 2) got_rel[beats] = obj_rel;
                beats++;
            end
            if (pop) pops++;
            if (busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        if (busy) busy_cyc++;
        h = hit; ht = hit_type; c = coin;
        if (!done) check("done_timeout", 0, 1);
    endtask

    vec_t vecs [10];

    initial begin
        int beats, pops, lat, bc;
        logic h, c;
        logic [1:0] ht;
        logic [15:0] none;
        none = 16'hF7FF;

        //        o0              o1              o2            n  scr ln j s bt r0  r1 pp h ht c ca
        vecs[0] = V(mk(80,0,1),  mk(90,2,2),  mk(100,0,0), 3, 85, 2, 0, 1, 2, 5,  15, 1, 0, 0, 0, 2);
        vecs[1] = V(mk(80,0,1),  mk(90,2,2),  mk(100,0,0), 3, 85, 2, 0, 0, 2, 5,  15, 1, 1, 2, 0, 2);
        vecs[2] = V(mk(50,1,1),  none,        none,        1, 45, 1, 1, 0, 1, 5,  0,  0, 0, 0, 0, 1);
        vecs[3] = V(mk(50,1,1),  none,        none,        1, 45, 1, 0, 0, 1, 5,  0,  0, 1, 1, 0, 1);
`ifdef OBJ_SCANNER_COIN_EN
        vecs[4] = V(mk(100,1,3), none,        none,        1, 96, 1, 0, 0, 1, 4,  0,  0, 0, 0, 1, 1);
`else
        vecs[4] = V(mk(100,1,3), none,        none,        1, 96, 1, 0, 0, 1, 4,  0,  0, 1, 3, 0, 1);
`endif
        vecs[5] = V(mk(200,0,0), mk(50,1,0),  none,        2, 100,1, 0, 0, 1, 100,0,  0, 0, 0, 0, 2);
        vecs[6] = V(mk(50,3,0),  mk(60,0,0),  none,        2, 100,0, 0, 0, 0, 0,  0,  1, 0, 0, 0, 1);
        vecs[7] = V(mk(499,0,0), mk(500,0,0), none,        2, 100,2, 0, 0, 1, 399,0,  0, 0, 0, 0, 2);
        vecs[8] = V(mk(108,0,2), mk(107,0,0), none,        2, 100,0, 0, 0, 2, 8,  7,  0, 1, 0, 0, 2);
        vecs[9] = V(mk(103,0,1), mk(104,0,2), none,        2, 100,0, 0, 0, 2, 3,  4,  0, 1, 1, 0, 2);

        reset = 1'b1; frame_start = 1'b0; scroll_pos = '0;
        player_lane = '0; player_jump = 1'b0; player_slide = 1'b0;
        for (int k = 0; k < 16; k++) mem[k] = 16'hF7FF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_outputs",
              int'({rd_index, pop, obj_valid, obj_rel, obj_lane, obj_type,
                    busy, done, hit, hit_type, coin}), 0);

        // Empty FIFO
        load({none, none, none}, 0);
        run_frame(beats, pops, lat, bc, h, ht, c);
        check("empty_latency", lat, 2);
        check("empty_busy", bc, 2);
        check("empty_beats", beats, 0);
        check("empty_pops", pops, 0);
        check("empty_hit", int'(h), 0);

        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            load(vecs[v].obj, vecs[v].n);
            scroll_pos   = vecs[v].scroll;
            player_lane  = vecs[v].lane;
            player_jump  = vecs[v].jump;
            player_slide = vecs[v].slide;
            run_frame(beats, pops, lat, bc, h, ht, c);
            @(negedge clk);
            check($sformatf("v%0d_beats", v), beats, vecs[v].beats);
            if (vecs[v].beats > 0) check($sformatf("v%0d_rel0", v), int'(got_rel[0]), int'(vecs[v].rel0));
            if (vecs[v].beats > 1) check($sformatf("v%0d_rel1", v), int'(got_rel[1]), int'(vecs[v].rel1));
            check($sformatf("v%0d_pops", v), pops, vecs[v].pops);
            check($sformatf("v%0d_latency", v), lat, vecs[v].n + 2 + vecs[v].pops);
            check($sformatf("v%0d_hit", v), int'(h), int'(vecs[v].hit));
            check($sformatf("v%0d_hit_type", v), int'(ht), int'(vecs[v].htype));
            check($sformatf("v%0d_coin", v), int'(c), int'(vecs[v].coin));
            check($sformatf("v%0d_count_after", v), cnt, vecs[v].cnt_after);
        end

        // Reset during the third SCAN cycle of a full queue
        @(negedge clk);
        for (int k = 0; k < 16; k++) mem[k] = mk(10, 0, 0);
        cnt = 16; scroll_pos = 12'd100; player_lane = 2'd1;
        player_jump = 1'b0; player_slide = 1'b0;
        pops = pop_total;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_scan_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_outputs",
              int'({rd_index, pop, obj_valid, obj_rel, obj_lane, obj_type,
                    busy, done, hit, hit_type, coin}), 0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_reset_no_pop", pop_total - pops, 0);
        check("mid_reset_count", cnt, 16);
        check("mid_reset_idle", int'(busy), 0);

        // Full queue, everything behind: all 16 popped
        run_frame(beats, pops, lat, bc, h, ht, c);
        @(negedge clk);
        check("full_pops", pops, 16);
        check("full_latency", lat, 16 + 2 + 16);
        check("full_beats", beats, 0);
        check("full_hit", int'(h), 0);
        check("full_count_after", cnt, 0);
        check("full_rd_index_wrap", int'(rd_index), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/obj_scanner.md
Name: obj_scanner

Overview:
- Per-frame consumer of the obstacle FIFO.
- On each `frame_start` it walks every queued 16-bit object by driving `rd_index` and reading the combinational `rd_obj`.
- It streams each object's screen-relative distance to the renderer and detects player collisions.
- After the walk it pops objects that have fallen behind the player from the FIFO front. It is the only block that drives `pop`; the spawner drives `push`.

Parameters:
- `ADDR_WIDTH`, 4, FIFO index width; queue depth is 2**ADDR_WIDTH.
- `VIEW_DIST`, 12'd400, objects with `rel < VIEW_DIST` are streamed as visible.
- `HIT_WIN`, 12'd8, an object with `rel < HIT_WIN` overlaps the player.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `frame_start`  in  1  one-cycle pulse per video frame.
- `scroll_pos`  in  12  player world position.
- `player_lane`  in  2  lane 0..2.
- `player_jump`  in  1  player airborne.
- `player_slide`  in  1  player sliding.
- `num`  in  ADDR_WIDTH+1  FIFO occupancy.
- `rd_obj`  in  16  FIFO read data; [11:0] pos, [13:12] lane, [15:14] type.
- `rd_index`  out  ADDR_WIDTH  FIFO read index.
- `pop`  out  1  FIFO pop strobe.
- `obj_valid`  out  1  stream beat valid.
- `obj_rel`  out  12  pos − scroll_pos.
- `obj_lane`  out  2  object lane.
- `obj_type`  out  2  object type.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle end-of-frame pulse.
- `hit`  out  1  collision pulse, coincident with `done`.
- `hit_type`  out  2  type of the first colliding object.
- `coin`  out  1  coin-collect pulse, coincident with `done`.

Behaviour:
- **Reset:** state IDLE. `rd_index`, `pop`, `obj_valid`, `obj_rel`, `obj_lane`, `obj_type`, `busy`, `done`, `hit`, `hit_type` and `coin` all 0. All accumulators cleared. A reset in any state aborts the scan and returns to IDLE next cycle; no pop is issued after reset.
- **States:** IDLE → SCAN → POP → DONE → IDLE.
- **IDLE:**
  - On `frame_start`, latch `scroll_pos`, `player_lane`, `player_jump`, `player_slide`, and `num` (into n).
  - Clear `hit_flag`, `coin_flag` and `pass_cnt`; set `front_run` = 1.
  - Go to SCAN, or to POP if n = 0.
- **SCAN:**
  - Drive `rd_index` = i, starting at 0. Each cycle evaluate `rd_obj` combinationally.
  - `rel` = (pos − scroll_latched) mod 4096. `rel[11]` = 1 means the object is behind the player.
  - Objects with lane 3 are ignored entirely (no stream beat, not passed, no collision); this covers the FIFO's empty value 16'hF7FF.
  - **Passed:** if `rel[11]` and `front_run`, increment `pass_cnt`. Otherwise clear `front_run`. Only a contiguous run from the front is popped.
  - **Overlap:** `rel < HIT_WIN` and lane = `player_lane`. Overlap causes a collision by type:
    - type 0 (wall): always.
    - type 1 (low barrier): unless jump.
    - type 2 (high barrier): unless slide.
    - type 3: see Optional Feature.
  - On the first collision, set `hit_flag` and capture `hit_type`.
  - **Stream:** if `!rel[11] && rel < VIEW_DIST`, register a beat: `obj_valid` = 1 and `obj_rel`, `obj_lane`, `obj_type` valid the cycle after index i is presented.
  - Go to POP after i = n−1.
- **Latency:** for n objects, `frame_start` at cycle T gives SCAN on T+1..T+n and the last beat at T+n+1.
- **POP:** assert `pop` for exactly `pass_cnt` consecutive cycles (0 allowed), then go to DONE.
- **DONE:** one cycle with `done` = 1, `hit` = `hit_flag`, `coin` = `coin_flag`. Return to IDLE.
- **Boundaries:**
  - `frame_start` while `busy` is ignored.
  - Pushes during a scan do not disturb indices; the latched n bounds the walk.
  - n = 2**ADDR_WIDTH is scanned fully and `rd_index` wraps only after its last use.
  - `pass_cnt` is ADDR_WIDTH+1 bits and never exceeds n.
  - `rel` arithmetic is 12-bit modular. Objects more than 2047 ahead read as behind; the spawner guarantees spawn distance < 2048.

Optional Feature:
- Macro `OBJ_SCANNER_COIN_EN`.
- **Defined:** type 3 is a coin. An overlapping coin sets `coin_flag` and never sets `hit`. Coins are streamed and popped like other objects.
- **Undefined:** type 3 is treated as a wall (always collides). `coin` is tied to 0.

Test Plan:
- **Empty FIFO.** num=0, `frame_start` → `busy` 2 cycles, no `obj_valid`, no `pop`, `done` 2 cycles after `frame_start`, `hit`=0.
- **Pop behind, no collision.** FIFO {pos 80 lane 0 type 1, pos 90 lane 2 type 2, pos 100 lane 0 type 0}, scroll 85, lane 2, slide=1.
  - Beats rel 5 and rel 15; rel 4091 not streamed.
  - `pop` for exactly 1 cycle, `hit`=0.
- **Collision capture.** Same FIFO, scroll 85, lane 2, slide=0 → `hit`=1, `hit_type`=2; next frame num=2.
- **Jump clears low barrier.** Single object pos 50 lane 1 type 1, scroll 45, lane 1: jump=1 → `hit`=0; jump=0 → `hit`=1.
- **Reset mid-scan.** 16 objects all behind; assert `reset` on the 3rd SCAN cycle → no `pop`, all outputs 0 next cycle, num unchanged at 16.
- **Coin (`OBJ_SCANNER_COIN_EN` defined).** Type 3 at pos 100, scroll 96, same lane → `coin`=1, `hit`=0. With the macro undefined → `hit`=1, `hit_type`=3.
